// File: rtl/midi_pkg.sv
// ============================================================================
// Module      : midi_pkg
// Description : Shared MIDI transmit types, status constants and length rule.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package midi_pkg;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] d1;
    logic [7:0] d2;
  } midi_msg_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } tx_state_t;

  localparam logic [7:0] ST_NOTE_OFF = 8'h80;
  localparam logic [7:0] ST_SYSCOM   = 8'hF0;
  localparam logic [7:0] ST_REALTIME = 8'hF8;

  // Bytes on the wire for a status byte, status included.
  function automatic logic [1:0] msg_len(input logic [7:0] status);
    logic [1:0] len;
    len = 2'd1;
    if (status < ST_SYSCOM)
      len = (status[7:4] == 4'hC || status[7:4] == 4'hD) ? 2'd2 : 2'd3;
    else if (status == 8'hF1 || status == 8'hF3)
      len = 2'd2;
    else if (status == 8'hF2)
      len = 2'd3;
    return len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/midi_uart_tx.sv
// ============================================================================
// Module      : midi_uart_tx
// Description : Byte-level 8N1 serialiser; accepts the next byte in the last
//               clock of the stop bit so consecutive frames abut.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module midi_uart_tx #(
  parameter int BIT_CYC = 1600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_byte_valid,
  output logic       o_byte_ready,
  input  logic [7:0] i_byte_data,
  output logic       o_txd
);

  localparam logic [10:0] c_BIT_LAST = 11'(BIT_CYC - 1);

  logic        r_busy;
  logic [10:0] r_bit_cnt;
  logic [3:0]  r_bit_idx;
  logic [8:0]  r_shift;
  logic        r_txd;
  logic        w_bit_end;
  logic        w_frame_end;

  assign w_bit_end    = (r_bit_cnt == c_BIT_LAST);
  assign w_frame_end  = w_bit_end && (r_bit_idx == 4'd9);
  assign o_byte_ready = !r_busy || w_frame_end;
  assign o_txd        = r_txd;

  // Bit index 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= 1'b0;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '1;
      r_txd     <= 1'b1;
    end else if (i_byte_valid && o_byte_ready) begin
      r_busy    <= 1'b1;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= {1'b1, i_byte_data};
      r_txd     <= 1'b0;
    end else if (r_busy) begin
      if (w_bit_end) begin
        r_bit_cnt <= '0;
        if (r_bit_idx == 4'd9) begin
          r_busy <= 1'b0;
          r_txd  <= 1'b1;
        end else begin
          r_bit_idx <= r_bit_idx + 4'd1;
          r_txd     <= r_shift[0];
          r_shift   <= {1'b1, r_shift[8:1]};
        end
      end else begin
        r_bit_cnt <= r_bit_cnt + 11'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/midi_tx_encoder.sv
// ============================================================================
// Module      : midi_tx_encoder
// Description : MIDI OUT path: message FIFO, per-status length sequencing and
//               31250-baud 8N1 serialisation. Optional running status is
//               enabled by defining MIDI_RUNNING_STATUS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module midi_tx_encoder
  import midi_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 31250,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLOCK_50,
  input  logic                          reset_n,
  input  logic                          msg_valid,
  output logic                          msg_ready,
  input  logic [7:0]                    msg_status,
  input  logic [7:0]                    msg_data1,
  input  logic [7:0]                    msg_data2,
  output logic                          midi_txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          drop_err
);

  localparam int          BIT_CYC = CLK_HZ / BAUD;
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] c_ONE   = (AW + 1)'(1);
  localparam logic [AW:0] c_DEPTH = (AW + 1)'(FIFO_DEPTH);

  midi_msg_t   r_fifo [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        r_drop_err;
  tx_state_t   r_state;
  midi_msg_t   r_cur;
  logic [1:0]  r_len;
  logic [1:0]  r_byte_idx;

  logic [AW:0] w_level;
  logic        w_empty;
  logic        w_push;
  logic        w_keep;
  logic        w_pop;
  logic        w_skip;
  midi_msg_t   w_head;
  logic        w_byte_valid;
  logic        w_byte_ready;
  logic [7:0]  w_byte_data;

  assign w_level    = r_wr_ptr - r_rd_ptr;
  assign w_empty    = (w_level == '0);
  assign msg_ready  = (w_level != c_DEPTH);
  assign w_push     = msg_valid && msg_ready;
  assign w_keep     = w_push && msg_status[7];
  assign w_pop      = (r_state == IDLE) && !w_empty;
  assign w_head     = r_fifo[r_rd_ptr[AW-1:0]];
  assign fifo_level = w_level;
  assign drop_err   = r_drop_err;
  assign tx_busy    = (r_state != IDLE) || !w_empty;

  always_ff @(posedge CLOCK_50) begin
    if (w_keep)
      r_fifo[r_wr_ptr[AW-1:0]] <= {msg_status, msg_data1, msg_data2};
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_drop_err <= 1'b0;
    end else begin
      r_drop_err <= w_push && !msg_status[7];
      if (w_keep)
        r_wr_ptr <= r_wr_ptr + c_ONE;
    end
  end

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] r_last_status;
  logic       w_voice;

  assign w_voice = (w_head.status >= ST_NOTE_OFF) && (w_head.status < ST_SYSCOM);
  assign w_skip  = w_voice && (w_head.status == r_last_status);

  // System common forgets the running status; realtime is transparent to it.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n)
      r_last_status <= '0;
    else if (w_pop) begin
      if (w_voice)
        r_last_status <= w_head.status;
      else if (w_head.status < ST_REALTIME)
        r_last_status <= '0;
    end
  end
`else
  assign w_skip = 1'b0;
`endif

  assign w_byte_valid = (r_state == LOAD);
  always_comb begin
    w_byte_data = r_cur.status;
    case (r_byte_idx)
      2'd1:    w_byte_data = r_cur.d1 & 8'h7F;
      2'd2:    w_byte_data = r_cur.d2 & 8'h7F;
      default: w_byte_data = r_cur.status;
    endcase
  end

  // LOAD offers one byte at a time; STOP waits out the final frame.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_rd_ptr   <= '0;
      r_cur      <= '0;
      r_len      <= 2'd1;
      r_byte_idx <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_cur      <= w_head;
            r_len      <= msg_len(w_head.status);
            r_byte_idx <= w_skip ? 2'd1 : 2'd0;
            r_rd_ptr   <= r_rd_ptr + c_ONE;
            r_state    <= LOAD;
          end
        end
        LOAD: begin
          if (w_byte_ready) begin
            if ((r_byte_idx + 2'd1) < r_len)
              r_byte_idx <= r_byte_idx + 2'd1;
            else
              r_state <= STOP;
          end
        end
        STOP: begin
          if (w_byte_ready)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  midi_uart_tx #(
    .BIT_CYC (BIT_CYC)
  ) u_uart (
    .clk          (CLOCK_50),
    .rst_n        (reset_n),
    .i_byte_valid (w_byte_valid),
    .o_byte_ready (w_byte_ready),
    .i_byte_data  (w_byte_data),
    .o_txd        (midi_txd)
  );

endmodule

`default_nettype wire

// File: tb/tb_midi_tx_encoder.sv
// ============================================================================
// Module      : tb_midi_tx_encoder
// Description : Directed self-checking bench; decodes midi_txd frames and
//               compares them with hand-written byte lists.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_midi_tx_encoder;

  localparam int CLK_HZ = 250_000;
  localparam int BAUD   = 31250;
  localparam int BC     = 8;
  localparam int DEPTH  = 4;

  logic       CLOCK_50   = 1'b0;
  logic       reset_n    = 1'b0;
  logic       msg_valid  = 1'b0;
  logic [7:0] msg_status = 8'h00;
  logic [7:0] msg_data1  = 8'h00;
  logic [7:0] msg_data2  = 8'h00;
  logic       msg_ready;
  logic       midi_txd;
  logic       tx_busy;
  logic [2:0] fifo_level;
  logic       drop_err;

  always #5 CLOCK_50 = ~CLOCK_50;

  midi_tx_encoder #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset_n    (reset_n),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready),
    .msg_status (msg_status),
    .msg_data1  (msg_data1),
    .msg_data2  (msg_data2),
    .midi_txd   (midi_txd),
    .tx_busy    (tx_busy),
    .fifo_level (fifo_level),
    .drop_err   (drop_err)
  );

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Line monitor: samples mid-bit, records frame start cycles and bytes.
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         st_q[$];
  int         frame_err = 0;
  bit         mon_act   = 1'b0;
  int         mon_cnt   = 0;
  logic [7:0] mon_sh    = 8'h00;

  always @(negedge CLOCK_50) begin
    if (!reset_n) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (midi_txd === 1'b0) begin
        mon_act = 1'b1;
        mon_cnt = 0;
        st_q.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % BC == BC / 2) begin
        if (mon_cnt / BC == 0) begin
          if (midi_txd !== 1'b0) frame_err++;
        end else if (mon_cnt / BC <= 8) begin
          mon_sh[mon_cnt / BC - 1] = midi_txd;
        end else begin
          if (midi_txd !== 1'b1) frame_err++;
          rx_q.push_back(mon_sh);
          mon_act = 1'b0;
        end
      end
    end
  end

  int acc_cyc  = 0;
  int idle_cyc = 0;

  task automatic push(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2);
    int t;
    t = 0;
    @(negedge CLOCK_50);
    msg_valid  = 1'b1;
    msg_status = s;
    msg_data1  = d1;
    msg_data2  = d2;
    while (msg_ready !== 1'b1 && t < 3000) begin
      @(negedge CLOCK_50);
      t++;
    end
    check_val("push_ready", msg_ready, 1);
    @(posedge CLOCK_50);
    acc_cyc = cyc + 1;
    #1 msg_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge CLOCK_50);
    while (tx_busy !== 1'b0 && t < 5000) begin
      @(negedge CLOCK_50);
      t++;
    end
    idle_cyc = cyc;
    check_val("idle_reached", tx_busy, 0);
    repeat (3) @(negedge CLOCK_50);
  endtask

  task automatic e(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  task automatic check_bytes(input string tag);
    logic [31:0] act;
    check_val({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      act = (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hFFFF_FFFF;
      check_val($sformatf("%s_byte%0d", tag, i), act, {24'h0, exp_q[i]});
    end
    rx_q.delete();
    exp_q.delete();
    st_q.delete();
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1_acc;
    int lows;
    int t;
    int s2;

    // Reset state
    repeat (3) @(negedge CLOCK_50);
    check_val("rst_txd", midi_txd, 1);
    check_val("rst_ready", msg_ready, 1);
    check_val("rst_busy", tx_busy, 0);
    check_val("rst_level", fifo_level, 0);
    check_val("rst_drop", drop_err, 0);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    // T1: note on, timing of the three frames
    push(8'h90, 8'h3C, 8'h64);
    t1_acc = acc_cyc;
    wait_idle();
    check_val("t1_frames", st_q.size(), 3);
    if (st_q.size() >= 3) begin
      check_val("t1_first_start", st_q[0] - t1_acc, 2);
      check_val("t1_gap01", st_q[1] - st_q[0], 10 * BC);
      check_val("t1_gap12", st_q[2] - st_q[1], 10 * BC);
      check_val("t1_busy_end", idle_cyc - st_q[0], 30 * BC);
    end
    e(8'h90); e(8'h3C); e(8'h64);
    check_bytes("t1");

    // T3: message lengths, data bit7 masking, dropped status
    push(8'hC0, 8'h85, 8'h00);
    push(8'hF8, 8'h11, 8'h22);
    push(8'hF2, 8'h10, 8'h20);
    wait_idle();
    e(8'hC0); e(8'h05); e(8'hF8); e(8'hF2); e(8'h10); e(8'h20);
    check_bytes("t3");
    push(8'h3C, 8'h01, 8'h02);
    @(negedge CLOCK_50);
    check_val("t3_drop_pulse", drop_err, 1);
    check_val("t3_drop_level", fifo_level, 0);
    @(negedge CLOCK_50);
    check_val("t3_drop_end", drop_err, 0);
    lows = 0;
    for (int i = 0; i < 20 * BC; i++) begin
      @(negedge CLOCK_50);
      if (midi_txd !== 1'b1) lows++;
    end
    check_val("t3_drop_line", lows, 0);
    check_val("t3_drop_busy", tx_busy, 0);
    check_bytes("t3drop");

    // T4/T5: running status stimulus
    push(8'h90, 8'h3C, 8'h64);
    push(8'h90, 8'h40, 8'h64);
    push(8'hF8, 8'h00, 8'h00);
    push(8'h90, 8'h41, 8'h64);
    push(8'hF1, 8'h05, 8'h00);
    push(8'h90, 8'h42, 8'h64);
    wait_idle();
`ifdef MIDI_RUNNING_STATUS_EN
    e(8'h90); e(8'h3C); e(8'h64); e(8'h40); e(8'h64);
    e(8'hF8); e(8'h41); e(8'h64);
    e(8'hF1); e(8'h05); e(8'h90); e(8'h42); e(8'h64);
`else
    e(8'h90); e(8'h3C); e(8'h64); e(8'h90); e(8'h40); e(8'h64);
    e(8'hF8); e(8'h90); e(8'h41); e(8'h64);
    e(8'hF1); e(8'h05); e(8'h90); e(8'h42); e(8'h64);
`endif
    check_bytes("t4");

    // T2: fill the FIFO while the line is busy
    push(8'hB0, 8'h07, 8'h01);
    repeat (4) @(negedge CLOCK_50);
    push(8'h80, 8'h11, 8'h22);
    push(8'h90, 8'h33, 8'h44);
    push(8'hA0, 8'h55, 8'h66);
    push(8'hE0, 8'h77, 8'h08);
    @(negedge CLOCK_50);
    check_val("t2_full_ready", msg_ready, 0);
    check_val("t2_full_level", fifo_level, 4);
    check_val("t2_full_busy", tx_busy, 1);
    push(8'h8F, 8'h01, 8'h02);
    wait_idle();
    e(8'hB0); e(8'h07); e(8'h01); e(8'h80); e(8'h11); e(8'h22);
    e(8'h90); e(8'h33); e(8'h44); e(8'hA0); e(8'h55); e(8'h66);
    e(8'hE0); e(8'h77); e(8'h08); e(8'h8F); e(8'h01); e(8'h02);
    check_bytes("t2");

    // T6: reset in the middle of a data bit of the second byte
    push(8'h90, 8'h3C, 8'h64);
    push(8'h80, 8'h01, 8'h02);
    t = 0;
    while (st_q.size() < 2 && t < 2000) begin
      @(negedge CLOCK_50);
      t++;
    end
    check_val("t6_second_frame", (st_q.size() >= 2) ? 1 : 0, 1);
    s2 = (st_q.size() >= 2) ? st_q[1] : cyc;
    t = 0;
    while (cyc < s2 + 2 * BC + BC / 2 && t < 2000) begin
      @(negedge CLOCK_50);
      t++;
    end
    check_val("t6_pre_txd", midi_txd, 0);
    #2 reset_n = 1'b0;
    #1;
    check_val("t6_rst_txd", midi_txd, 1);
    check_val("t6_rst_level", fifo_level, 0);
    check_val("t6_rst_ready", msg_ready, 1);
    check_val("t6_rst_busy", tx_busy, 0);
    repeat (2) @(negedge CLOCK_50);
    reset_n = 1'b1;
    check_val("t6_partial", rx_q.size(), 1);
    rx_q.delete();
    st_q.delete();
    repeat (2) @(negedge CLOCK_50);
    push(8'hC5, 8'h12, 8'h00);
    wait_idle();
    e(8'hC5); e(8'h12);
    check_bytes("t6");

    check_val("frame_err", frame_err, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
